// File: rtl/activation_scheduler_pkg.sv
// Shared definitions for the activation scheduler: lane-index sizing,
// FSM state encoding and lane slicing for packed lane vectors.
package activation_scheduler_pkg;

    localparam int DEFAULT_NUM_NEURON = 6;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LANE_IDX_W = idx_width(DEFAULT_NUM_NEURON);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Bit offset of lane `lane` in a vector of `width`-bit lanes.
    function automatic int lane_base(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/activation_scheduler_lane_picker.sv
// Combinational priority encoder: reports whether any mask bit is set and
// the index of the lowest set bit. Shared with the other schedulers.
module lane_picker
    import activation_scheduler_pkg::*;
#(
    parameter int N     = DEFAULT_NUM_NEURON,
    parameter int IDX_W = LANE_IDX_W
) (
    input  logic [N-1:0]     mask,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scanning downward lets the lowest set bit be the last one written.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                any = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/activation_scheduler.sv
// Shares one activation-LUT read port across NUM_NEURON lanes: issues one
// read per valid lane in ascending order and returns the gathered results.
module activation_scheduler
    import activation_scheduler_pkg::*;
#(
    parameter int NUM_NEURON  = 6,
    parameter int ADDR_SIZE   = 10,
    parameter int VALUE_SIZE  = 9,
    parameter int LUT_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_NEURON*ADDR_SIZE-1:0]  in_values,
    input  logic [NUM_NEURON-1:0]            in_mask,
    input  logic                             in_start,
    output logic                             in_ready,
    input  logic                             lut_stable,
    output logic                             lut_req,
    output logic [ADDR_SIZE-1:0]             lut_addr,
    input  logic [VALUE_SIZE-1:0]            lut_data,
    output logic [NUM_NEURON*VALUE_SIZE-1:0] out_values,
    output logic [NUM_NEURON-1:0]            out_mask,
    output logic                             out_valid,
    input  logic                             out_ready,
    output sched_state_t                     dbg_state
);

    // Handshakes: a start is taken on a clock edge where in_start & in_ready;
    // a result is handed off on an edge where out_valid & out_ready, and
    // out_valid with its data stays unchanged until that edge.

    localparam int IDX_W = idx_width(NUM_NEURON);
    localparam logic [NUM_NEURON-1:0] LANE0_BIT = NUM_NEURON'(1);

    sched_state_t                    state;
    logic [NUM_NEURON*ADDR_SIZE-1:0] in_values_r;
    logic [NUM_NEURON-1:0]           pending;
    logic [IDX_W-1:0]                lut_lane;
    logic                            tag_vld  [LUT_LATENCY];
    logic [IDX_W-1:0]                tag_lane [LUT_LATENCY];

    logic                  pick_any;
    logic [IDX_W-1:0]      pick_idx;
    logic [ADDR_SIZE-1:0]  pick_value;
    logic [NUM_NEURON-1:0] pending_next;
    logic                  drain_empty;

    assign dbg_state = state;

    lane_picker #(
        .N     (NUM_NEURON),
        .IDX_W (IDX_W)
    ) u_picker (
        .mask (pending),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        pick_value   = in_values_r[lane_base(int'(pick_idx), ADDR_SIZE) +: ADDR_SIZE];
        pending_next = pending & ~(LANE0_BIT << pick_idx);
    end

    // True when nothing will still be in flight after the coming edge: the
    // last tag stage retires on that same edge.
    always_comb begin
        drain_empty = !lut_req;
        for (int i = 0; i < LUT_LATENCY - 1; i++) begin
            if (tag_vld[i]) begin
                drain_empty = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b0;
            lut_req     <= 1'b0;
            lut_addr    <= '0;
            lut_lane    <= '0;
            out_values  <= '0;
            out_mask    <= '0;
            out_valid   <= 1'b0;
            in_values_r <= '0;
            pending     <= '0;
            for (int i = 0; i < LUT_LATENCY; i++) begin
                tag_vld[i]  <= 1'b0;
                tag_lane[i] <= '0;
            end
        end else begin
            tag_vld[0]  <= lut_req;
            tag_lane[0] <= lut_lane;
            for (int i = 1; i < LUT_LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_lane[i] <= tag_lane[i-1];
            end

            if (tag_vld[LUT_LATENCY-1]) begin
                out_values[lane_base(int'(tag_lane[LUT_LATENCY-1]), VALUE_SIZE) +: VALUE_SIZE]
                    <= lut_data;
            end

            case (state)
                ST_IDLE: begin
                    lut_req <= 1'b0;
                    if (in_start && in_ready) begin
                        in_values_r <= in_values;
                        pending     <= in_mask;
                        out_mask    <= in_mask;
                        out_values  <= '0;
                        in_ready    <= 1'b0;
                        state       <= (in_mask == '0) ? ST_DONE : ST_ISSUE;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    if (lut_stable && pick_any) begin
                        lut_req  <= 1'b1;
                        lut_addr <= pick_value;
                        lut_lane <= pick_idx;
                        pending  <= pending_next;
                        if (pending_next == '0) begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        lut_req <= 1'b0;
                        if (!pick_any) begin
                            state <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    lut_req <= 1'b0;
                    if (drain_empty) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end

                ST_DONE: begin
                    // An empty-mask job arrives here with out_valid still low;
                    // it rises one edge later, and out_ready is ignored until then.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_scheduler.sv
// Bench for activation_scheduler with 4 lanes and a 2-cycle LUT returning
// (addr+1) mod 512; issue order, timing and results go through expected queues.
module tb_activation_scheduler;
    import activation_scheduler_pkg::*;

    localparam int NN  = 4;
    localparam int AW  = 10;
    localparam int VW  = 9;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NN*AW-1:0]  in_values = '0;
    logic [NN-1:0]     in_mask = '0;
    logic              in_start = 1'b0;
    logic              in_ready;
    logic              lut_stable = 1'b1;
    logic              lut_req;
    logic [AW-1:0]     lut_addr;
    logic [VW-1:0]     lut_data;
    logic [NN*VW-1:0]  out_values;
    logic [NN-1:0]     out_mask;
    logic              out_valid;
    logic              out_ready = 1'b0;
    sched_state_t      dbg_state;

    int checks = 0;
    int failures = 0;

    logic [AW-1:0]    exp_q[$];
    int               exp_edge_q[$];
    logic [NN*VW-1:0] exp_res_q[$];
    logic [AW-1:0]    obs_addr_q[$];
    int               obs_edge_q[$];
    int               valid_edge;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    activation_scheduler #(
        .NUM_NEURON  (NN),
        .ADDR_SIZE   (AW),
        .VALUE_SIZE  (VW),
        .LUT_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_values  (in_values),
        .in_mask    (in_mask),
        .in_start   (in_start),
        .in_ready   (in_ready),
        .lut_stable (lut_stable),
        .lut_req    (lut_req),
        .lut_addr   (lut_addr),
        .lut_data   (lut_data),
        .out_values (out_values),
        .out_mask   (out_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dbg_state  (dbg_state)
    );

    // ---------------- shared LUT model ----------------
    logic          lut_pipe_v [LAT];
    logic [AW-1:0] lut_pipe_a [LAT];

    always @(posedge clk) begin
        lut_pipe_v[0] <= lut_req;
        lut_pipe_a[0] <= lut_addr;
        for (int i = 1; i < LAT; i++) begin
            lut_pipe_v[i] <= lut_pipe_v[i-1];
            lut_pipe_a[i] <= lut_pipe_a[i-1];
        end
    end

    // Garbage outside the valid window exposes captures at the wrong cycle.
    assign lut_data = (lut_pipe_v[LAT-1] === 1'b1) ? VW'(lut_pipe_a[LAT-1] + 10'd1) : 9'h1aa;

    function automatic logic [VW-1:0] lut_model(input logic [AW-1:0] a);
        int v;
        v = (int'(a) + 1) % 512;
        return v[VW-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_expected(input logic [NN*AW-1:0] vals, input logic [NN-1:0] mask,
                                 input int stall_lo, input int stall_hi, output int exp_valid);
        int e;
        int last;
        logic [AW-1:0] a;
        logic [NN*VW-1:0] res;
        e = 1;
        last = 0;
        res = '0;
        for (int lane = 0; lane < NN; lane++) begin
            if (mask[lane]) begin
                while (e >= stall_lo && e <= stall_hi) e++;
                a = vals[lane*AW +: AW];
                exp_q.push_back(a);
                exp_edge_q.push_back(e);
                res[lane*VW +: VW] = lut_model(a);
                last = e;
                e++;
            end
        end
        exp_valid = (mask == '0) ? 1 : last + LAT + 1;
        exp_res_q.push_back(res);
    endtask

    task automatic run_op(input logic [NN*AW-1:0] vals, input logic [NN-1:0] mask,
                          input int stall_lo, input int stall_hi);
        int w;
        obs_addr_q.delete();
        obs_edge_q.delete();
        valid_edge = -1;
        w = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        in_values  = vals;
        in_mask    = mask;
        in_start   = 1'b1;
        lut_stable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            lut_stable = (n >= stall_lo && n <= stall_hi) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (lut_req === 1'b1) begin
                obs_addr_q.push_back(lut_addr);
                obs_edge_q.push_back(n);
            end
            if (out_valid === 1'b1) begin
                valid_edge = n;
                break;
            end
            @(negedge clk);
        end
        lut_stable = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || lut_req !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: in_ready=%b lut_req=%b out_valid=%b required 0/0/0",
                     in_ready, lut_req, out_valid);
        end
        checks++;
        if (out_values !== '0 || out_mask !== '0 || lut_addr !== '0) begin
            failures++;
            $display("FAIL reset_data: out_values=%h out_mask=%b lut_addr=%0d required 0",
                     out_values, out_mask, lut_addr);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_issue_pattern(input string name, input logic [NN*AW-1:0] vals,
                                      input logic [NN-1:0] mask, input int stall_lo,
                                      input int stall_hi);
        int exp_valid;
        int ee;
        int oe;
        int i;
        logic [AW-1:0] ea;
        logic [AW-1:0] oa;
        logic [NN*VW-1:0] er;
        push_expected(vals, mask, stall_lo, stall_hi, exp_valid);
        run_op(vals, mask, stall_lo, stall_hi);
        checks++;
        if (obs_addr_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s req_count: got %0d required %0d", name, obs_addr_q.size(), exp_q.size());
        end
        i = 0;
        while (exp_q.size() > 0) begin
            ea = exp_q.pop_front();
            ee = exp_edge_q.pop_front();
            checks++;
            if (obs_addr_q.size() == 0) begin
                failures++;
                $display("FAIL %s req%0d: missing, required addr=%0d edge=%0d", name, i, ea, ee);
            end else begin
                oa = obs_addr_q.pop_front();
                oe = obs_edge_q.pop_front();
                if (oa !== ea || oe !== ee) begin
                    failures++;
                    $display("FAIL %s req%0d: addr=%0d edge=%0d required addr=%0d edge=%0d",
                             name, i, oa, oe, ea, ee);
                end
            end
            i++;
        end
        checks++;
        if (valid_edge !== exp_valid) begin
            failures++;
            $display("FAIL %s valid_edge: got %0d required %0d", name, valid_edge, exp_valid);
        end
        er = exp_res_q.pop_front();
        checks++;
        if (out_values !== er) begin
            failures++;
            $display("FAIL %s out_values: got %h required %h", name, out_values, er);
        end
        checks++;
        if (out_mask !== mask) begin
            failures++;
            $display("FAIL %s out_mask: got %b required %b", name, out_mask, mask);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_back_pressure();
        int exp_valid;
        logic [NN*AW-1:0] vals;
        logic [NN*VW-1:0] er;
        vals = {10'd1023, 10'd511, 10'd100, 10'd3};
        push_expected(vals, 4'b1111, 0, 0, exp_valid);
        exp_q.delete();
        exp_edge_q.delete();
        er = exp_res_q.pop_front();
        run_op(vals, 4'b1111, 0, 0);
        checks++;
        if (valid_edge !== exp_valid) begin
            failures++;
            $display("FAIL bp valid_edge: got %0d required %0d", valid_edge, exp_valid);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_start  = (c == 2) ? 1'b1 : 1'b0;
            in_values = {10'd9, 10'd8, 10'd7, 10'd6};
            in_mask   = 4'b0001;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_values !== er || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp hold%0d: out_valid=%b out_values=%h in_ready=%b required 1/%h/0",
                         c, out_valid, out_values, in_ready, er);
            end
        end
        @(negedge clk);
        in_start  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp accept: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (lut_req !== 1'b0 || dbg_state !== ST_IDLE) begin
                failures++;
                $display("FAIL bp ignored_start%0d: lut_req=%b state=%0d required 0/%0d",
                         c, lut_req, dbg_state, ST_IDLE);
            end
        end
    endtask

    task automatic test_reset_mid_issue();
        @(negedge clk);
        in_values = {10'd1023, 10'd511, 10'd100, 10'd3};
        in_mask   = 4'b1111;
        in_start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (lut_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL rst_mid: lut_req=%b out_valid=%b in_ready=%b state=%0d required 0/0/0/%0d",
                     lut_req, out_valid, in_ready, dbg_state, ST_IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid release: in_ready=%b required 1", in_ready);
        end
        test_issue_pattern("post_reset", {10'd7, 10'd6, 10'd5, 10'd77}, 4'b0001, 0, 0);
    endtask

    task automatic test_random();
        logic [NN*AW-1:0] vals;
        logic [NN-1:0] mask;
        int lo;
        for (int r = 0; r < 6; r++) begin
            vals[31:0]  = $urandom();
            vals[39:32] = 8'($urandom());
            mask = 4'($urandom_range(0, 15));
            lo   = $urandom_range(1, 4);
            test_issue_pattern("random", vals, mask, lo, lo + $urandom_range(0, 3));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_issue_pattern("full", {10'd1023, 10'd511, 10'd100, 10'd3}, 4'b1111, 0, 0);
        test_issue_pattern("sparse", {10'd40, 10'd0, 10'd20, 10'd0}, 4'b1010, 0, 0);
        test_issue_pattern("empty", {10'd5, 10'd6, 10'd7, 10'd8}, 4'b0000, 0, 0);
        test_issue_pattern("stall", {10'd1023, 10'd511, 10'd100, 10'd3}, 4'b1111, 2, 4);
        test_back_pressure();
        test_reset_mid_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/activation_scheduler.md
Name: activation_scheduler

Overview:
- Time-multiplexes one shared activation-LUT read port across NUM_NEURON neuron pre-activation values, instead of one LUT per neuron.
- Accepts a lane vector plus a lane-valid mask and issues one LUT read per valid lane, in ascending lane order.
- Collects the LUT results into an output vector and hands it downstream with a valid/ready handshake.
- Sits between the neuron accumulators and the layer output buffer in the layer-multiplexed datapath.

Parameters:
- NUM_NEURON, 6, number of lanes.
- ADDR_SIZE, 10, width of each pre-activation value (LUT address).
- VALUE_SIZE, 9, width of each LUT result.
- LUT_LATENCY, 1, cycles from lut_req/lut_addr to lut_data valid; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_values  in  NUM_NEURON*ADDR_SIZE  pre-activation lanes; lane i is bits [i*ADDR_SIZE +: ADDR_SIZE].
- in_mask  in  NUM_NEURON  lane valid mask.
- in_start  in  1  request strobe; accepted when in_start & in_ready.
- in_ready  out  1  high only in IDLE.
- lut_stable  in  1  shared LUT is initialised and readable.
- lut_req  out  1  read strobe for the shared LUT.
- lut_addr  out  ADDR_SIZE  read address.
- lut_data  in  VALUE_SIZE  read data, valid LUT_LATENCY cycles after lut_req.
- out_values  out  NUM_NEURON*VALUE_SIZE  activated lanes; lanes that were invalid read 0.
- out_mask  out  NUM_NEURON  copy of the accepted in_mask.
- out_valid  out  1  result available; held until out_ready.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset values: in_ready=0 during rst, then 1 in IDLE. lut_req=0, lut_addr=0, out_values=0, out_mask=0, out_valid=0. FSM=IDLE. Tag pipeline is cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On in_start & in_ready, register in_values and in_mask, and clear the result buffer.
  - If mask==0, go to DONE. Otherwise go to ISSUE.
- ISSUE:
  - Each cycle with lut_stable=1, drive lut_req=1 and lut_addr = lane of the lowest still-pending mask bit, then clear that pending bit.
  - With lut_stable=0, lut_req=0 and nothing advances (stall).
  - After the last pending lane issues, go to DRAIN.
- Tag pipeline: a LUT_LATENCY-deep shift register carries {valid, lane index}. When the tag emerges, write lut_data into the result slot for that lane.
- DRAIN: wait until the tag pipeline is empty, then go to DONE.
- DONE:
  - out_valid=1, with out_values and out_mask stable.
  - On out_ready, go to IDLE (out_valid drops the next cycle).
  - out_ready while not valid is ignored.
- Latency, with k valid lanes and no stalls:
  - Start accepted at edge 0.
  - Issues occur in cycles 1..k.
  - out_valid rises at edge k+LUT_LATENCY+1.
  - With mask==0, out_valid rises at edge 1.
- in_start while in_ready=0 is ignored; no queueing.
- lut_stable falling mid-ISSUE stalls only new issues. Requests already in flight still complete.
- rst mid-operation aborts immediately. In-flight tags are discarded and all outputs return to reset values.

Decomposition:
- Shared package: lane-index width constant ($clog2(NUM_NEURON)), FSM state encoding, and the lane-slice helper function.
- One sub-module, lane_picker: a combinational priority encoder that takes the pending mask and returns {any, lowest index}. It is reused by other schedulers.

Test Plan:
Common setup: NUM_NEURON=4, ADDR_SIZE=10, VALUE_SIZE=9, LUT_LATENCY=2. The LUT model returns (addr+1) mod 512.
1. Full mask, lut_stable=1:
   - Stimulus: in_values lanes = {3,100,511,1023}, mask=4'b1111, start at edge 0.
   - Required: lut_addr 3,100,511,1023 in cycles 1..4. out_valid at edge 7 with lanes {4,101,0,0}. out_mask=1111.
2. Sparse mask:
   - Stimulus: mask=4'b1010, lanes 1=20 and 3=40.
   - Required: exactly two lut_req pulses (addr 20, then 40). out_valid at edge 5 with lanes {0,21,0,41}.
3. Empty mask:
   - Stimulus: mask=0.
   - Required: no lut_req. out_valid at edge 1 with out_values=0.
4. LUT stall:
   - Stimulus: scenario 1 with lut_stable=0 for cycles 2-4.
   - Required: issues at cycles 1,5,6,7. out_valid at edge 10 with the same data as scenario 1.
5. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles after out_valid; in_start pulsed meanwhile.
   - Required: out_values held, in_ready=0, start ignored. Accept on out_ready; in_ready=1 next cycle.
6. Reset mid-ISSUE:
   - Stimulus: rst at cycle 2 of scenario 1.
   - Required: next cycle lut_req=0, out_valid=0, in_ready=1 after rst drops. A following run with mask=0001 yields exactly lane 0's result.
